// File: rtl/usb_rcv_ctrl_if.sv
// Handshake bundle between the USB receive datapath (edge/EOP detect, shifter)
// and the receive control unit.
interface usb_rcv_ctrl_if;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;
    logic       byte_received;
    logic [6:0] byte_count;

    modport slave (
        input  d_edge, eop, shift_enable, rcv_data,
        output rcving, w_enable, r_error, byte_received, byte_count
    );

    modport master (
        output d_edge, eop, shift_enable, rcv_data,
        input  rcving, w_enable, r_error, byte_received, byte_count
    );
endinterface

// File: rtl/usb_rcv_ctrl.sv
// USB full-speed receive sequencer: bit/byte counting, SYNC check, FIFO write
// strobe and sticky framing-error flag.
module usb_rcv_ctrl #(
    parameter logic [7:0] SYNC_BYTE = 8'h80,
    parameter int         MAX_BYTES = 64
) (
    input  logic          clk,
    input  logic          n_rst,
    usb_rcv_ctrl_if.slave bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SYNC     = 3'd1;
    localparam logic [2:0] DATA     = 3'd2;
    localparam logic [2:0] STORE    = 3'd3;
    localparam logic [2:0] ERR      = 3'd4;
    localparam logic [2:0] EOP_WAIT = 3'd5;
    localparam logic [6:0] MAX_CNT  = 7'(MAX_BYTES);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_byte_cnt;
    logic       r_err;
    logic       r_byte_rcvd;
    logic       w_bit_tick;
    logic       w_eop_tick;

    assign w_bit_tick = bus.shift_enable & ~bus.eop;
    assign w_eop_tick = bus.shift_enable & bus.eop;

    // byte_received has priority over EOP; they cannot coincide in DATA anyway
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (bus.d_edge) w_next = SYNC;
            SYNC: begin
                if (r_byte_rcvd)     w_next = (bus.rcv_data == SYNC_BYTE) ? DATA : ERR;
                else if (w_eop_tick) w_next = ERR;
            end
            DATA: begin
                if (r_byte_rcvd)     w_next = (r_byte_cnt < MAX_CNT) ? STORE : ERR;
                else if (w_eop_tick) w_next = (r_bit_cnt == 3'd0) ? EOP_WAIT : ERR;
            end
            STORE:    w_next = DATA;
            ERR:      if (w_eop_tick) w_next = EOP_WAIT;
            EOP_WAIT: if (w_bit_tick) w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_bit_cnt   <= 3'd0;
            r_byte_cnt  <= 7'd0;
            r_err       <= 1'b0;
            r_byte_rcvd <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE)
                r_bit_cnt <= 3'd0;
            else if (w_bit_tick)
                r_bit_cnt <= r_bit_cnt + 3'd1;
            // pulse lands in the cycle when the shifter holds the full byte
            r_byte_rcvd <= (r_state != IDLE) && w_bit_tick && (r_bit_cnt == 3'd7);
            if (r_state == IDLE && bus.d_edge) begin
                r_byte_cnt <= 7'd0;
                r_err      <= 1'b0;
            end else begin
                if (r_state == STORE)
                    r_byte_cnt <= r_byte_cnt + 7'd1;
                if (w_next == ERR && r_state != ERR)
                    r_err <= 1'b1;
            end
        end
    end

    assign bus.rcving        = (r_state != IDLE);
    assign bus.w_enable      = (r_state == STORE);
    assign bus.r_error       = r_err;
    assign bus.byte_received = r_byte_rcvd;
    assign bus.byte_count    = r_byte_cnt;
endmodule

// File: tb/tb_usb_rcv_ctrl.sv
// Randomized packet-level bench for usb_rcv_ctrl with a packet outcome model.
module tb_usb_rcv_ctrl;
    localparam logic [7:0] SYNC = 8'h80;
    localparam int         MAXB = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       cur_bit = 1'b0;
    logic [7:0] sh = 8'h00;
    int         n_chk = 0;
    int         n_err = 0;
    int         n_brx = 0;
    int         n_wen = 0;
    int         n_wen_bad = 0;
    logic       prev_brx = 1'b0;
    logic [7:0] wr_log [0:1023];

    usb_rcv_ctrl_if bus();

    usb_rcv_ctrl #(.SYNC_BYTE(SYNC), .MAX_BYTES(MAXB)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // receive shift register model: LSB-first, new bit enters at the MSB
    always @(posedge clk) if (bus.shift_enable && !bus.eop) sh <= {cur_bit, sh[7:1]};
    assign bus.rcv_data = sh;

    always @(negedge clk) begin
        prev_brx <= bus.byte_received;
        if (bus.byte_received) n_brx <= n_brx + 1;
        if (bus.w_enable) begin
            wr_log[n_wen[9:0]] <= bus.rcv_data;
            n_wen <= n_wen + 1;
            if (!prev_brx) n_wen_bad <= n_wen_bad + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic send_bit(input logic b, input logic e, output logic brx);
        @(negedge clk);
        cur_bit = b;
        bus.eop = e;
        bus.shift_enable = 1'b1;
        bus.d_edge = 1'($urandom % 2);
        @(negedge clk);
        bus.shift_enable = 1'b0;
        bus.d_edge = 1'b0;
        brx = bus.byte_received;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] v);
        logic brx;
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], 1'b0, brx);
            chk("brx_pulse", brx, (i == 7));
        end
    endtask

    task automatic pkt(input logic [7:0] sb, input int nd, input int extra,
                       input logic [7:0] d0, input logic [7:0] d1);
        logic [7:0] dat [8];
        int   b0, w0, exp_wr;
        logic exp_err, brx;
        for (int i = 0; i < 8; i++) dat[i] = 8'($urandom);
        dat[0] = d0;
        dat[1] = d1;
        exp_wr  = (sb != SYNC) ? 0 : ((nd < MAXB) ? nd : MAXB);
        exp_err = (sb != SYNC) || (nd > MAXB) || (extra != 0);
        @(negedge clk); bus.d_edge = 1'b1;
        @(negedge clk); bus.d_edge = 1'b0;
        chk("rcving_rise", bus.rcving, 1);
        chk("err_clr", bus.r_error, 0);
        chk("cnt_clr", bus.byte_count, 0);
        b0 = n_brx;
        w0 = n_wen;
        send_byte(sb);
        chk("err_after_sync", bus.r_error, (sb != SYNC));
        for (int i = 0; i < nd; i++) send_byte(dat[i]);
        for (int i = 0; i < extra; i++) begin
            send_bit(1'($urandom % 2), 1'b0, brx);
            chk("brx_extra", brx, 0);
        end
        send_bit(1'b0, 1'b1, brx);
        send_bit(1'b0, 1'b1, brx);
        send_bit(1'b1, 1'b0, brx);
        repeat (2) @(negedge clk);
        chk("rcving_fall", bus.rcving, 0);
        chk("n_brx", n_brx - b0, nd + 1);
        chk("n_wen", n_wen - w0, exp_wr);
        chk("byte_count", bus.byte_count, exp_wr);
        chk("r_error", bus.r_error, exp_err);
        for (int i = 0; i < exp_wr; i++) chk("wdata", wr_log[w0 + i], dat[i]);
        repeat ($urandom_range(1, 5)) @(negedge clk);
        chk("cnt_hold", bus.byte_count, exp_wr);
        chk("err_hold", bus.r_error, exp_err);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {bus.rcving, bus.w_enable, bus.r_error, bus.byte_received, bus.byte_count}, 0);
    endtask

    task automatic reset_mid_packet();
        logic brx;
        int   w0;
        @(negedge clk); bus.d_edge = 1'b1;
        @(negedge clk); bus.d_edge = 1'b0;
        send_byte(SYNC);
        send_byte(8'h5A);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, brx);
        chk("pre_rst_cnt", bus.byte_count, 1);
        w0 = n_wen;
        @(negedge clk); n_rst = 1'b0;
        @(negedge clk); chk_all_zero("rst_mid_1");
        @(negedge clk); chk_all_zero("rst_mid_2");
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("rst_after");
        chk("rst_nowen", n_wen - w0, 0);
    endtask

    initial begin
        logic [7:0] s;
        int nd, ex;
        bus.d_edge = 1'b0;
        bus.eop = 1'b0;
        bus.shift_enable = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_state");
        n_rst = 1'b1;
        @(negedge clk);
        pkt(SYNC, 2, 0, 8'hA5, 8'h3C);
        pkt(8'h81, 2, 0, 8'h11, 8'h22);
        pkt(SYNC, 1, 3, 8'h77, 8'h00);
        pkt(SYNC, 5, 0, 8'h01, 8'h02);
        pkt(8'hFF, 1, 0, 8'h33, 8'h44);
        pkt(SYNC, 2, 0, 8'hC3, 8'h99);
        pkt(SYNC, 0, 0, 8'h00, 8'h00);
        pkt(SYNC, 4, 0, 8'hDE, 8'hAD);
        reset_mid_packet();
        for (int k = 0; k < 40; k++) begin
            s = 8'($urandom);
            if (s == SYNC) s = 8'h81;
            if ($urandom % 8 != 0) s = SYNC;
            nd = int'($urandom % 7);
            ex = ($urandom % 3 == 0) ? int'($urandom_range(1, 6)) : 0;
            pkt(s, nd, ex, 8'($urandom), 8'($urandom));
        end
        chk("wen_timing", n_wen_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
